// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM encodings,
// register offsets within the 16-byte window, and STATUS/CTRL bit positions.
package uart_pkg;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   localparam logic [1:0] OFS_TXDATA = 2'd0;
   localparam logic [1:0] OFS_STATUS = 2'd1;
   localparam logic [1:0] OFS_CTRL   = 2'd2;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;

   localparam int unsigned CTRL_TX_EN  = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; accepts a push while full when a
// pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count_o = wptr_q - rptr_q;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data bus: register decode,
// readdata mux, TX FIFO, baud counter and frame FSM with registered txd.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] aluout,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        uart_txd,
   output logic        tx_irq
);

   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   logic        sel;
   logic [1:0]  offset;
   logic        wr_txdata;
   logic        wr_status;
   logic        wr_ctrl;

   logic        fifo_full;
   logic        fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]  fifo_head;
   logic        pop;

   uart_state_t   state_q,  state_d;
   logic [BW-1:0] baud_q,   baud_d;
   logic [2:0]    bitidx_q, bitidx_d;
   logic [7:0]    shift_q,  shift_d;
   logic          txd_q,    txd_d;
   logic [1:0]    ctrl_q,   ctrl_d;
   logic          ovf_q,    ovf_d;

   logic          tx_en;
   logic [31:0]   cnt_wide;
   logic [3:0]    cnt_sat;
   logic [31:0]   status;
   logic          unused_bits;

   assign sel       = (aluout[31:4] == BASE_ADDR[31:4]);
   assign offset    = aluout[3:2];
   assign wr_txdata = memwrite && sel && (offset == OFS_TXDATA);
   assign wr_status = memwrite && sel && (offset == OFS_STATUS);
   assign wr_ctrl   = memwrite && sel && (offset == OFS_CTRL);
   assign tx_en     = ctrl_q[CTRL_TX_EN];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (wr_txdata),
      .wdata_i (writedata[7:0]),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bitidx_d = bitidx_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_en && !fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               baud_d  = BAUD_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == '0) begin
               baud_d   = BAUD_LOAD;
               bitidx_d = '0;
               state_d  = ST_DATA;
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (baud_q == '0) begin
               baud_d = BAUD_LOAD;
               if (bitidx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bitidx_d = bitidx_q + 3'd1;
                  shift_d  = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         ST_STOP: begin
            // Chain straight into the next frame so back-to-back bytes have no idle gap.
            if (baud_q == '0) begin
               if (tx_en && !fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_head;
                  baud_d  = BAUD_LOAD;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // txd is derived from the next state so the line moves on the same edge as the FSM.
      txd_d = 1'b1;
      if (state_d == ST_START)     txd_d = 1'b0;
      else if (state_d == ST_DATA) txd_d = shift_d[0];
   end

   always_comb begin
      ctrl_d = wr_ctrl ? writedata[1:0] : ctrl_q;
      ovf_d  = (wr_txdata && fifo_full && !pop)
             | (ovf_q && !(wr_status && writedata[STAT_OVF]));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bitidx_q <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         ctrl_q   <= 2'b01;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bitidx_q <= bitidx_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      cnt_wide = 32'(fifo_count);
      cnt_sat  = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

      status                        = '0;
      status[STAT_FULL]             = fifo_full;
      status[STAT_EMPTY]            = fifo_empty;
      status[STAT_BUSY]             = (state_q != ST_IDLE);
      status[STAT_OVF]              = ovf_q;
      status[STAT_CNT_LSB +: 4]     = cnt_sat;

      readdata = '0;
      if (sel) begin
         case (offset)
            OFS_STATUS: readdata = status;
            OFS_CTRL:   readdata[1:0] = ctrl_q;
            default:    readdata = '0;
         endcase
      end
   end

   assign uart_txd    = txd_q;
   assign tx_irq      = fifo_empty && ctrl_q[CTRL_IRQ_EN];
   assign unused_bits = ^{aluout[1:0], writedata[31:8]};

endmodule
